serv_bufreg_ctrl: RTL and testbench
===================================

Name: serv_bufreg_ctrl

Overview:
- Sequencer for the bit-serial buffer register: generates its count, enable, init, loop and operand-enable controls for one memory-access or shift operation.
- Runs a 32-cycle INIT pass (rs1+imm address build), holds the data-bus request, then an optional 32-cycle loop pass or shamt-cycle shift pass.
- Sits between decode/state logic (requester) and the buffer register plus data-bus interface.

Parameters:
- DBUS_TIMEOUT, 0, cycles allowed in BUS before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_req  in  1  operation request; held by requester until o_ack
- o_ack  out  1  request accepted (combinational: IDLE & i_req)
- i_rs1_sel  in  1  add rs1 during INIT
- i_imm_sel  in  1  add imm during INIT
- i_mem  in  1  operation needs data-bus cycle
- i_loop  in  1  run 32-cycle loop pass after bus ack
- i_shift  in  1  shift operation (feature only)
- i_shamt  in  5  shift amount (feature only)
- o_cnt  out  3  cnt[4:2] to buffer register
- o_cnt_r  out  4  one-hot of cnt[1:0]
- o_en  out  1  buffer register shift enable
- o_init  out  1  INIT pass active
- o_loop  out  1  recirculate buffer register
- o_rs1_en  out  1  rs1 operand gate
- o_imm_en  out  1  imm operand gate
- o_dbus_cyc  out  1  data-bus request
- i_dbus_ack  in  1  data-bus acknowledge
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, INIT, BUS, RUN, SHIFT. Internal 5-bit cnt; o_cnt=cnt[4:2]; o_cnt_r=1<<cnt[1:0].
- Reset (i_rst_n=0 at posedge): state IDLE, cnt=0, latched flags 0. Reset values: o_cnt_r=4'b0001, o_cnt=0, and o_en, o_init, o_loop, o_rs1_en, o_imm_en, o_dbus_cyc, o_busy, o_done, o_err all 0. Mid-operation reset aborts with no o_done; o_dbus_cyc drops the cycle after.
- IDLE: on i_req, o_ack=1 and i_rs1_sel/i_imm_sel/i_mem/i_loop/i_shift/i_shamt are latched. Next state INIT, cnt=0. i_req outside IDLE is ignored (o_ack=0).
- INIT: o_en=o_init=1; o_rs1_en/o_imm_en = latched selects. cnt increments each cycle and wraps 31->0 after exactly 32 cycles. Exit order: mem -> BUS; else shift -> SHIFT; else IDLE with o_done.
- Buffer register captures lsb[0] at cnt=0 and lsb[1] at cnt=1 of INIT; o_cnt_r must be exact on those cycles.
- BUS: o_dbus_cyc=1, o_en=0, cnt held at 0.
  - i_dbus_ack -> RUN if loop latched, else IDLE with o_done the following cycle.
  - Ack on the first BUS cycle is legal.
- RUN: o_en=o_loop=1, o_init=0, operand gates 0, for 32 cycles; then IDLE with o_done. Net rotation 32 leaves buffer contents unchanged.
- Watchdog (DBUS_TIMEOUT=N>0): counts BUS cycles. If no ack after N cycles: o_err pulse, IDLE, o_dbus_cyc deasserts, no o_done. Ack in the same cycle as expiry wins.
- o_done and o_err are never both asserted. o_busy=0 in the cycle o_done is visible.

Optional Feature:
- SERV_BUFREG_SHIFT_EN.
- Defined: SHIFT state; o_en=o_loop=1 for shamt cycles (right rotate by shamt); shamt=0 skips SHIFT straight to o_done. SHIFT follows INIT only when mem=0.
- Undefined: i_shift/i_shamt are ignored and SHIFT logic is absent; shift-flagged requests behave as plain INIT-only ops.

Decomposition:
- Shared package: state enum, CNT_W=5, WORD_BITS=32.
- One natural sub-module, serv_bufreg_cnt: 5-bit counter with one-hot cnt_r, clear/enable inputs and wrap flag.

Test Plan:
- Reset held mid-INIT (cnt=17) -> next cycle IDLE, o_cnt=0, o_cnt_r=0001, no o_done.
- Request rs1=1, imm=1, mem=1, loop=0 -> o_init high for exactly 32 cycles; o_cnt_r sequence 1,2,4,8 repeating; o_cnt steps 0..7; o_dbus_cyc rises on cycle 33.
- BUS with ack after 5 cycles, loop=1 -> 32 o_en/o_loop cycles, then one o_done; buffer value 0x1008 preserved.
- DBUS_TIMEOUT=8, no ack -> o_err pulse after 8 BUS cycles, IDLE, no o_done; repeat with ack on cycle 8 -> o_done, no o_err.
- Shift feature, mem=0, shamt=5 -> exactly 5 o_loop cycles then o_done; shamt=0 -> o_done directly after INIT.
- i_req held through a whole operation -> exactly one o_ack per IDLE visit; back-to-back ops accepted in the cycle after o_done.

Source files
------------

// File: rtl/serv_bufreg_ctrl_pkg.sv
// Shared types and sizes for the bit-serial buffer register sequencer.
package serv_bufreg_ctrl_pkg;

  localparam int unsigned CNT_W     = 5;
  localparam int unsigned WORD_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_BUS,
    ST_RUN,
    ST_SHIFT
  } state_e;

endpackage

// File: rtl/serv_bufreg_cnt.sv
// Bit counter for one serial word: binary count, one-hot of the low two bits,
// and a flag on the last bit of the word.
module serv_bufreg_cnt
  import serv_bufreg_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [3:0]       cnt_r_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_r_o = 4'b0001 << cnt_q[1:0];
  assign wrap_o  = (cnt_q == CNT_W'(WORD_BITS - 1));

endmodule

// File: rtl/serv_bufreg_ctrl.sv
// Buffer register sequencer: INIT address pass, data-bus hold, optional loop pass.
// Optional right-rotate SHIFT pass is built when SERV_BUFREG_SHIFT_EN is defined.
module serv_bufreg_ctrl
  import serv_bufreg_ctrl_pkg::*;
#(
  parameter int unsigned DBUS_TIMEOUT = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  output logic       o_ack,
  input  logic       i_rs1_sel,
  input  logic       i_imm_sel,
  input  logic       i_mem,
  input  logic       i_loop,
  input  logic       i_shift,
  input  logic [4:0] i_shamt,
  output logic [2:0] o_cnt,
  output logic [3:0] o_cnt_r,
  output logic       o_en,
  output logic       o_init,
  output logic       o_loop,
  output logic       o_rs1_en,
  output logic       o_imm_en,
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [31:0] TMO_LAST = (DBUS_TIMEOUT == 0) ? 32'd0 : 32'(DBUS_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             rs1_q, imm_q, mem_q, loop_q;
  logic             done_q, done_d, err_q, err_d;
  logic [31:0]      tmo_q;
  logic             tmo_hit, shift_go, shift_last;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap;

  // Any state change restarts the count, so every pass begins at bit 0.
  serv_bufreg_cnt u_cnt (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clr_i   (state_d != state_q),
    .en_i    (cnt_en),
    .cnt_o   (cnt),
    .cnt_r_o (o_cnt_r),
    .wrap_o  (cnt_wrap)
  );

`ifdef SERV_BUFREG_SHIFT_EN
  logic       shift_q;
  logic [4:0] shamt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_q <= 1'b0;
      shamt_q <= '0;
    end else if (state_q == ST_IDLE && i_req) begin
      shift_q <= i_shift;
      shamt_q <= i_shamt;
    end
  end

  assign shift_go   = shift_q && (shamt_q != 5'd0);
  assign shift_last = (cnt == shamt_q - 5'd1);
`else
  logic unused_shift;
  assign unused_shift = ^{i_shift, i_shamt, cnt[1:0]};
  assign shift_go     = 1'b0;
  assign shift_last   = 1'b0;
`endif

  assign tmo_hit = (DBUS_TIMEOUT != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    o_ack      = 1'b0;
    o_en       = 1'b0;
    o_init     = 1'b0;
    o_loop     = 1'b0;
    o_dbus_cyc = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          o_ack   = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        o_en   = 1'b1;
        o_init = 1'b1;
        cnt_en = 1'b1;
        if (cnt_wrap) begin
          if (mem_q) begin
            state_d = ST_BUS;
          end else if (shift_go) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_BUS: begin
        o_dbus_cyc = 1'b1;
        // An ack arriving on the expiry cycle still completes normally.
        if (i_dbus_ack) begin
          if (loop_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_RUN: begin
        o_en   = 1'b1;
        o_loop = 1'b1;
        cnt_en = 1'b1;
        if (cnt_wrap) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        o_en   = 1'b1;
        o_loop = 1'b1;
        cnt_en = 1'b1;
        if (shift_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      rs1_q   <= 1'b0;
      imm_q   <= 1'b0;
      mem_q   <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= (state_q == ST_BUS) ? tmo_q + 32'd1 : '0;
      if (state_q == ST_IDLE && i_req) begin
        rs1_q  <= i_rs1_sel;
        imm_q  <= i_imm_sel;
        mem_q  <= i_mem;
        loop_q <= i_loop;
      end
    end
  end

  assign o_cnt    = cnt[4:2];
  assign o_rs1_en = o_init & rs1_q;
  assign o_imm_en = o_init & imm_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_serv_bufreg_ctrl.sv
// Scoreboard bench for serv_bufreg_ctrl (watchdog set to 8 BUS cycles).
module tb_serv_bufreg_ctrl;

  typedef struct {
    logic        err;
    int          init_n;
    int          bus_n;
    int          loop_n;
    int          acks;
    logic [31:0] buf_v;
    logic        rs1;
    logic        imm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, rs1 = 1'b0, imm = 1'b0, mem = 1'b0, lp = 1'b0, sh = 1'b0;
  logic [4:0] shamt = '0;
  logic       dbus_ack = 1'b0;
  logic       ack, en, init, loop_o, rs1_en, imm_en, dbus_cyc, busy, done, err;
  logic [2:0] cnt;
  logic [3:0] cnt_r;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  serv_bufreg_ctrl #(.DBUS_TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ack(ack),
    .i_rs1_sel(rs1), .i_imm_sel(imm), .i_mem(mem), .i_loop(lp),
    .i_shift(sh), .i_shamt(shamt), .o_cnt(cnt), .o_cnt_r(cnt_r),
    .o_en(en), .o_init(init), .o_loop(loop_o), .o_rs1_en(rs1_en),
    .o_imm_en(imm_en), .o_dbus_cyc(dbus_cyc), .i_dbus_ack(dbus_ack),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: tallies per-operation activity and compares against the queue head.
  initial begin : monitor
    int          init_n = 0, bus_n = 0, loop_n = 0, acks = 0, idx = 0;
    logic        rst_prev = 1'b0;
    logic [31:0] bufm = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (rst_prev)
          chk("reset_state",
              {ack, busy, done, err, en, init, loop_o, rs1_en, imm_en, dbus_cyc, cnt, cnt_r},
              {10'b0, 3'b000, 4'b0001});
        rst_prev = 1'b1;
        init_n = 0; bus_n = 0; loop_n = 0; acks = 0; idx = 0;
      end else begin
        rst_prev = 1'b0;
        if (done || err) begin
          chk("done_err_exclusive", done & err, 0);
          chk("busy_at_end", busy, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("err_flag", err, e.err);
            chk("init_cycles", init_n, e.init_n);
            chk("bus_cycles", bus_n, e.bus_n);
            chk("loop_cycles", loop_n, e.loop_n);
            chk("acks_per_op", acks, e.acks);
            chk("buffer_value", bufm, e.buf_v);
          end
          init_n = 0; bus_n = 0; loop_n = 0; acks = 0; idx = 0;
        end
        if (ack) begin
          acks++;
          bufm = 32'h0000_1008;
          idx = 0;
        end
        if (init) begin
          chk("init_cnt", {cnt, cnt_r}, {3'(idx / 4), 4'b0001 << (idx % 4)});
          if (exp_q.size() != 0)
            chk("operand_gates", {rs1_en, imm_en}, {exp_q[0].rs1, exp_q[0].imm});
          idx++;
          init_n++;
        end
        if (dbus_cyc) begin
          chk("bus_en_low", en, 0);
          bus_n++;
        end
        if (loop_o) loop_n++;
        if (en && loop_o) bufm = {bufm[0], bufm[31:1]};
      end
    end
  end

  task automatic wait_end(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done || err) return;
    end
    chk("completion_timeout", 1, 0);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack) return;
    end
    chk("ack_timeout", 1, 0);
  endtask

  task automatic do_op(input logic r, input logic m, input logic mm, input logic l,
                       input logic s, input logic [4:0] sa, input int ack_at, input exp_t e);
    int k = 0;
    logic got = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rs1 = r; imm = m; mem = mm; lp = l; sh = s; shamt = sa; req = 1'b1;
    wait_ack();
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the latched copies must be used.
    req = 1'b0; rs1 = ~r; imm = ~m; mem = ~mm; lp = ~l; sh = ~s; shamt = ~sa;
    if (mm && ack_at > 0) begin
      for (int i = 0; i < 80 && !got; i++) begin
        @(negedge clk);
        if (dbus_cyc) begin
          k++;
          if (k == ack_at) begin
            dbus_ack = 1'b1;
            got = 1'b1;
          end
        end
      end
      if (!got) chk("bus_wait_timeout", 1, 0);
      @(posedge clk); #1;
      dbus_ack = 1'b0;
    end
    wait_end(120);
  endtask

  function automatic exp_t mk(input logic er, input int b, input int l, input logic [31:0] v,
                              input logic r, input logic m);
    exp_t e;
    e.err = er; e.init_n = 32; e.bus_n = b; e.loop_n = l; e.acks = 1;
    e.buf_v = v; e.rs1 = r; e.imm = m;
    return e;
  endfunction

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // mem, no loop, ack on first BUS cycle
    do_op(1, 1, 1, 0, 0, 0, 1, mk(0, 1, 0, 32'h1008, 1, 1));
    // mem + loop, ack on 5th BUS cycle: 32-cycle rotation preserves buffer
    do_op(0, 1, 1, 1, 0, 0, 5, mk(0, 5, 32, 32'h1008, 0, 1));
    // no ack: watchdog fires after 8 BUS cycles
    do_op(1, 0, 1, 0, 0, 0, 0, mk(1, 8, 0, 32'h1008, 1, 0));
    // ack on the expiry cycle wins
    do_op(1, 0, 1, 0, 0, 0, 8, mk(0, 8, 0, 32'h1008, 1, 0));
    // INIT-only op
    do_op(0, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 32'h1008, 0, 1));
`ifdef SERV_BUFREG_SHIFT_EN
    do_op(1, 1, 0, 0, 1, 5'd5, 0, mk(0, 0, 5, 32'h4000_0080, 1, 1));
`else
    do_op(1, 1, 0, 0, 1, 5'd5, 0, mk(0, 0, 0, 32'h1008, 1, 1));
`endif
    do_op(1, 1, 0, 0, 1, 5'd0, 0, mk(0, 0, 0, 32'h1008, 1, 1));

    // reset during INIT at cnt=17: no completion may follow
    @(posedge clk); #1;
    rs1 = 1; imm = 1; mem = 1; lp = 1; sh = 0; req = 1'b1;
    wait_ack();
    @(posedge clk); #1 req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init && cnt == 3'd4 && cnt_r == 4'b0001) break;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // request held across two back-to-back ops
    exp_q.push_back(mk(0, 0, 0, 32'h1008, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 32'h1008, 1, 0));
    #1;
    rs1 = 1; imm = 0; mem = 0; lp = 0; sh = 0; req = 1'b1;
    wait_end(60);
    @(posedge clk); #1 req = 1'b0;
    wait_end(60);

    repeat (4) @(posedge clk);
    chk("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
